// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - multi-port cache-line memory arbiter, round-robin or fixed priority
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RELEASE, all outputs registered.
module mem_arbiter #(
   parameter int NUM_PORTS       = 2,
   parameter int ADDRESS_SIZE    = 32,
   parameter int CACHE_LINE_SIZE = 128,
   parameter int ARB_MODE        = 0
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [NUM_PORTS-1:0]                 req_op_init,
   input  logic [NUM_PORTS-1:0]                 req_op,
   input  logic [NUM_PORTS*ADDRESS_SIZE-1:0]    req_address,
   input  logic [NUM_PORTS*CACHE_LINE_SIZE-1:0] req_data_in,
   output logic [CACHE_LINE_SIZE-1:0]           port_data_out,
   output logic [NUM_PORTS-1:0]                 port_data_ready,
   output logic [NUM_PORTS-1:0]                 grant,
   output logic                                 mem_op_init,
   output logic                                 mem_op,
   output logic [ADDRESS_SIZE-1:0]              mem_address,
   output logic [CACHE_LINE_SIZE-1:0]           mem_data_in,
   input  logic [CACHE_LINE_SIZE-1:0]           mem_data_out,
   input  logic                                 mem_data_ready,
   output logic                                 mem_op_done,
   output logic                                 memory_in_use
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [NUM_PORTS-1:0] GRANT_ONE = NUM_PORTS'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

   state_t           state;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] pick;
   logic             pick_valid;

   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
      int sum;
      sum = int'(base) + k;
      if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
      return IDX_W'(sum);
   endfunction

   // Scan from the lowest-priority end so the last hit is the winner.
   always_comb begin
      pick       = '0;
      pick_valid = 1'b0;
      if (ARB_MODE == 1) begin
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_op_init[i]) begin
               pick       = IDX_W'(i);
               pick_valid = 1'b1;
            end
         end
      end else begin
         for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req_op_init[rr_idx(last_grant, k)]) begin
               pick       = rr_idx(last_grant, k);
               pick_valid = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         grant           <= '0;
         winner          <= '0;
         last_grant      <= IDX_W'(NUM_PORTS - 1);
         port_data_ready <= '0;
         port_data_out   <= '0;
         mem_op_init     <= 1'b0;
         mem_op_done     <= 1'b0;
         mem_op          <= 1'b0;
         mem_address     <= '0;
         mem_data_in     <= '0;
         memory_in_use   <= 1'b0;
      end else begin
         port_data_ready <= '0;
         mem_op_init     <= 1'b0;
         mem_op_done     <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  grant         <= GRANT_ONE << pick;
                  winner        <= pick;
                  last_grant    <= pick;
                  mem_op        <= req_op[pick];
                  mem_address   <= req_address[int'(pick)*ADDRESS_SIZE +: ADDRESS_SIZE];
                  mem_data_in   <= req_data_in[int'(pick)*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
                  mem_op_init   <= 1'b1;
                  memory_in_use <= 1'b1;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (mem_data_ready) begin
                  port_data_out   <= mem_data_out;
                  port_data_ready <= grant;
                  mem_op_done     <= 1'b1;
                  state           <= RELEASE;
               end
            end
            RELEASE: begin
               // Hold until the served port drops its request so it is not served twice.
               if (!req_op_init[winner]) begin
                  grant         <= '0;
                  memory_in_use <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requester channels (instruction cache, data cache, ...); legal range 2..8.
REQ-002 Parameter ADDRESS_SIZE, default 32: address width.
REQ-003 Parameter CACHE_LINE_SIZE, default 128: line/data width.
REQ-004 Parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with port 0 highest.
REQ-005 The block SHALL have one clock; reset is synchronous and active-low. Ports `clk` and `reset` carry these.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 req_op_init  in  NUM_PORTS  per-port request; held high until that port's data_ready.
REQ-009 req_op  in  NUM_PORTS  per-port operation: 0 = read, 1 = write.
REQ-010 req_address  in  NUM_PORTS*ADDRESS_SIZE  per-port line address; port i in slice i.
REQ-011 req_data_in  in  NUM_PORTS*CACHE_LINE_SIZE  per-port write line.
REQ-012 port_data_out  out  CACHE_LINE_SIZE  read line returned to the granted port.
REQ-013 port_data_ready  out  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-014 grant  out  NUM_PORTS  one-hot owner of memory; zero when idle.
REQ-015 mem_op_init, mem_op  out  1 each  memory transaction start pulse and operation.
REQ-016 mem_address  out  ADDRESS_SIZE; mem_data_in  out  CACHE_LINE_SIZE.
REQ-017 mem_data_out  in  CACHE_LINE_SIZE; mem_data_ready  in  1  memory completion.
REQ-018 mem_op_done  out  1  one-cycle acknowledge to memory.
REQ-019 memory_in_use  out  1  high whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RELEASE.
REQ-021 IDLE: if any req_op_init bit is high, the arbiter SHALL select a winner, register grant, and latch that port's op, address and data. It SHALL then go to ISSUE; otherwise it stays in IDLE.
REQ-022 Round-robin selection: the search SHALL start at port (last_grant+1) mod NUM_PORTS, and the first requesting port wins. last_grant updates only when a grant is issued.
REQ-023 Fixed-priority selection: the lowest-index requesting port SHALL win.
REQ-024 ISSUE: mem_op_init SHALL be high for exactly one cycle, with mem_op, mem_address and mem_data_in driven from the latched values. The state then goes to WAIT.
REQ-025 mem_op, mem_address and mem_data_in SHALL stay stable from ISSUE through WAIT; requester input changes after the grant SHALL NOT affect them.
REQ-026 WAIT: on mem_data_ready=1, the block SHALL register mem_data_out into port_data_out, pulse port_data_ready[winner] for one cycle, pulse mem_op_done for one cycle, and go to RELEASE.
REQ-027 On writes, port_data_out SHALL still be updated; requesters ignore it.
REQ-028 RELEASE: the block SHALL stay while req_op_init[winner]=1, and go to IDLE with grant cleared once it is 0. This prevents re-serving a stale request.
REQ-029 Minimum latency: request at edge 0 gives grant at edge 1 and mem_op_init high in the cycle after edge 1. port_data_ready arrives one edge after mem_data_ready is sampled.
REQ-030 mem_data_ready seen outside WAIT SHALL be ignored.
REQ-031 A request arriving while the arbiter is busy SHALL wait; no request is lost or reordered beyond the arbitration policy.
REQ-032 Simultaneous requests from all ports in round-robin mode SHALL be served in rotating order with no port starved. Worst-case wait is NUM_PORTS-1 transactions.
REQ-033 port_data_out SHALL hold its last value between transactions.

Reset
REQ-034 With reset=0 at a rising edge: state SHALL be IDLE; grant, port_data_ready, mem_op_init and mem_op_done SHALL be 0; mem_op, mem_address, mem_data_in and port_data_out SHALL be 0; memory_in_use SHALL be 0; last_grant SHALL be NUM_PORTS-1, so port 0 wins first.
REQ-035 Reset asserted mid-transaction (ISSUE/WAIT/RELEASE) SHALL abandon the transaction. No port_data_ready or mem_op_done pulse is issued for it.
REQ-036 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-037 Single read: port 0 requests read at 0x00000040, and memory returns 0x...0011 after 5 cycles. Expected: grant=01, one mem_op_init pulse with mem_address=0x40, port_data_out=0x...0011, port_data_ready=01 for 1 cycle, mem_op_done for 1 cycle, then idle after op_init drops.
REQ-038 Contention with round-robin, NUM_PORTS=2: both ports request continuously for 4 transactions. Expected grant order 0,1,0,1.
REQ-039 Contention with ARB_MODE=1, NUM_PORTS=4: ports 1 and 3 request. Port 1 is served first, then port 3; port 0 joining during port 1's transaction is served before port 3.
REQ-040 Write stability: port 1 writes data 0xDEADBEEF at 0x80, then changes req_address to 0xC0 during WAIT. mem_address SHALL stay 0x80 and mem_op SHALL be 1 throughout.
REQ-041 Reset mid-WAIT: reset=0 for one cycle while waiting. Expected: all outputs zero and no port_data_ready pulse. The next port-0 request is served normally.
REQ-042 Stale-request guard: the requester holds req_op_init for 3 cycles after port_data_ready. Exactly one mem_op_init is observed for that request.
